// File: rtl/spi_slave_framed_if.sv
// Bus bundle for the framed SPI slave: serial lines plus local RX/TX handshake.
interface spi_slave_framed_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TX_DEPTH   = 4,
    parameter int unsigned LVL_W      = $clog2(TX_DEPTH) + 1
);
    logic                  MOSI;
    logic                  MISO;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_parity_err;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [LVL_W-1:0]      tx_level;
    logic                  tx_busy;

    modport slave (
        input  MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, rx_parity_err, tx_ready, tx_level, tx_busy
    );

    modport master (
        output MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, rx_parity_err, tx_ready, tx_level, tx_busy
    );
endinterface

// File: rtl/spi_slave_framed.sv
// Framed full-duplex 3-wire SPI slave: start bit, LSB-first payload, even parity.
// RX deframer, TX FIFO and TX framer all run on SCLK; MISO changes on the falling edge.
module spi_slave_framed #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TX_DEPTH   = 4,
    parameter int unsigned LVL_W      = $clog2(TX_DEPTH) + 1
) (
    input  logic              rst,
    input  logic              SCLK,
    spi_slave_framed_if.slave bus
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(TX_DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY} rx_state_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_GUARD} tx_state_e;

    rx_state_e             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_perr_q, rx_perr_d;
    logic                  rx_valid_q, rx_valid_d;

    tx_state_e             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shreg_q, tx_shreg_d;
    logic                  tx_bit_q, tx_bit_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  tx_pop;
    logic                  miso_q, miso_d;

    logic [DATA_WIDTH-1:0] mem_q [TX_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [TX_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  push;
    logic                  fifo_empty;

    assign fifo_empty = (level_q == '0);

    // RX deframer: hunt for start bit, collect payload, check parity on the last bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shreg_d = rx_shreg_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (bus.MOSI) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = '0;
                end
            end
            RX_DATA: begin
                rx_shreg_d[rx_cnt_q] = bus.MOSI;
                if (rx_cnt_q == LAST_BIT) begin
                    rx_state_d = RX_PARITY;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_PARITY: begin
                rx_data_d  = rx_shreg_q;
                rx_perr_d  = (bus.MOSI != (^rx_shreg_q));
                rx_valid_d = 1'b1;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // TX framer: pop a word, then emit start, payload, parity and one guard zero.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shreg_d = tx_shreg_q;
        tx_bit_d   = 1'b0;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE, TX_GUARD: begin
                // Guard pops directly so queued frames start every DATA_WIDTH+3 cycles.
                tx_state_d = TX_IDLE;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shreg_d = mem_q[rd_ptr_q];
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_bit_d   = 1'b1;
                tx_cnt_d   = '0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                tx_bit_d = tx_shreg_q[tx_cnt_q];
                if (tx_cnt_q == LAST_BIT) begin
                    tx_state_d = TX_PAR;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_PAR: begin
                tx_bit_d   = ^tx_shreg_q;
                tx_state_d = TX_GUARD;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        tx_busy_d = (tx_state_d == TX_START) || (tx_state_d == TX_DATA) ||
                    (tx_state_d == TX_PAR);
        miso_d    = tx_bit_q;
    end

    // TX FIFO: a write while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        mem_d    = mem_q;
        push     = bus.tx_valid && tx_ready_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.tx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d    = level_q + LVL_W'(push) - LVL_W'(tx_pop);
        tx_ready_d = (level_d != FULL_LVL);
    end

    // Control and datapath state, cleared by reset.
    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_shreg_q <= '0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_shreg_q <= '0;
            tx_bit_q   <= 1'b0;
            tx_busy_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tx_ready_q <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shreg_q <= rx_shreg_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_valid_q <= rx_valid_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shreg_q <= tx_shreg_d;
            tx_bit_q   <= tx_bit_d;
            tx_busy_q  <= tx_busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge SCLK) begin
        mem_q <= mem_d;
    end

    // MISO launches on the falling edge so the master samples a settled bit.
    always_ff @(negedge SCLK or posedge rst) begin
        if (rst) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= miso_d;
        end
    end

    assign bus.MISO          = miso_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.tx_ready      = tx_ready_q;
    assign bus.tx_level      = level_q;
    assign bus.tx_busy       = tx_busy_q;
endmodule
